// File: rtl/serial_divider_pkg.sv
// Shared state encodings and result constants for the serial divider.
// Constants are sized for the widest supported operand and scaled down by users.
package serial_divider_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    DIV_STATE_IDLE = 2'd0,
    DIV_STATE_RUN  = 2'd1,
    DIV_STATE_DONE = 2'd2
  } div_state_t;

  localparam logic [DIV_WIDTH-1:0] DIV_QUOT_BY_ZERO = '1;
  localparam logic [DIV_WIDTH-1:0] DIV_SIGNED_MIN   = 32'h8000_0000;

endpackage

// File: rtl/serial_divider_div_step.sv
// One combinational restoring-division iteration: shift in a dividend bit, trial-subtract.
// Zero latency; no flow control.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             dividend_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             quot_bit
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;

  assign shifted  = {rem_in, dividend_bit};
  assign quot_bit = (shifted >= {1'b0, divisor});
  // Partial remainder stays below the divisor, so a successful subtract fits in WIDTH bits.
  assign diff     = shifted[WIDTH-1:0] - divisor;
  assign rem_out  = quot_bit ? diff : shifted[WIDTH-1:0];

endmodule

// File: rtl/serial_divider.sv
// Radix-2 restoring divider for DIV/DIVU/REM/REMU: WIDTH+1 busy cycles, 1 for special cases.
// busy stalls the requester combinationally; DIV_CACHE_EN keeps the last result reusable from IDLE.
module serial_divider
  import serial_divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] remainder,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] QUOT_BY_ZERO = WIDTH'(DIV_QUOT_BY_ZERO >> (DIV_WIDTH - WIDTH));
  localparam logic [WIDTH-1:0] SIGNED_MIN   = WIDTH'(DIV_SIGNED_MIN >> (DIV_WIDTH - WIDTH));

  div_state_t       state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic             sgn_q;
  logic [WIDTH-1:0] rem_q, quot_q, dvs_q;
  logic [CW-1:0]    cnt_q;
  logic             neg_quot_q, neg_rem_q;

  logic             tuple_match, hold_ok, new_req, accept, is_special;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] rem_nxt, quot_nxt;
  logic             q_bit;

  assign tuple_match = (a == a_q) && (b == b_q) && (is_signed == sgn_q);

`ifdef DIV_CACHE_EN
  logic cache_vld_q;

  assign hold_ok = (state_q == DIV_STATE_DONE) || ((state_q == DIV_STATE_IDLE) && cache_vld_q);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cache_vld_q <= 1'b0;
    end else if (state_d == DIV_STATE_DONE) begin
      cache_vld_q <= 1'b1;
    end else if (state_d == DIV_STATE_RUN) begin
      cache_vld_q <= 1'b0;
    end
  end
`else
  assign hold_ok = (state_q == DIV_STATE_DONE);
`endif

  assign new_req    = start && !(tuple_match && hold_ok);
  assign is_special = (b == '0) || (is_signed && (a == SIGNED_MIN) && (b == '1));
  assign a_mag      = (is_signed && a[WIDTH-1]) ? -a : a;
  assign b_mag      = (is_signed && b[WIDTH-1]) ? -b : b;

  div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem_in       (rem_q),
    .dividend_bit (quot_q[WIDTH-1]),
    .divisor      (dvs_q),
    .rem_out      (rem_nxt),
    .quot_bit     (q_bit)
  );

  // The dividend shifts out of the quotient register's top as quotient bits shift in below.
  assign quot_nxt = {quot_q[WIDTH-2:0], q_bit};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= DIV_STATE_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    busy    = 1'b0;
    unique case (state_q)
      DIV_STATE_IDLE: begin
        if (start) begin
          accept  = new_req;
          busy    = new_req;
          state_d = (new_req && !is_special) ? DIV_STATE_RUN : DIV_STATE_DONE;
        end
      end
      DIV_STATE_RUN: begin
        busy = 1'b1;
        if (cnt_q == '0) begin
          state_d = DIV_STATE_DONE;
        end
      end
      DIV_STATE_DONE: begin
        if (!start) begin
          state_d = DIV_STATE_IDLE;
        end else if (new_req) begin
          accept  = 1'b1;
          busy    = 1'b1;
          state_d = is_special ? DIV_STATE_DONE : DIV_STATE_RUN;
        end
      end
      default: state_d = DIV_STATE_IDLE;
    endcase
    if (reset) begin
      busy = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      a_q        <= '0;
      b_q        <= '0;
      sgn_q      <= 1'b0;
      rem_q      <= '0;
      quot_q     <= '0;
      dvs_q      <= '0;
      cnt_q      <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      result     <= '0;
      remainder  <= '0;
    end else if (accept) begin
      a_q   <= a;
      b_q   <= b;
      sgn_q <= is_signed;
      if (is_special) begin
        result    <= (b == '0) ? QUOT_BY_ZERO : SIGNED_MIN;
        remainder <= (b == '0) ? a : '0;
      end else begin
        rem_q      <= '0;
        quot_q     <= a_mag;
        dvs_q      <= b_mag;
        cnt_q      <= CW'(WIDTH - 1);
        neg_quot_q <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
        neg_rem_q  <= is_signed && a[WIDTH-1];
      end
    end else if (state_q == DIV_STATE_RUN) begin
      rem_q  <= rem_nxt;
      quot_q <= quot_nxt;
      cnt_q  <= cnt_q - CW'(1);
      if (cnt_q == '0) begin
        result    <= neg_quot_q ? -quot_nxt : quot_nxt;
        remainder <= neg_rem_q ? -rem_nxt : rem_nxt;
      end
    end
  end

endmodule

// File: tb/tb_serial_divider.sv
// Randomized and directed bench for serial_divider against a transaction-level reference model.
module tb_serial_divider;

  localparam int WIDTH = 32;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        is_signed;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] result;
  logic [31:0] remainder;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: busy countdown, hold flag, latched tuple, expected outputs.
  int          m_left;
  bit          m_hold;
  bit          m_cache;
  logic [31:0] m_a, m_b;
  bit          m_s;
  logic [31:0] m_res, m_rem;
  logic [31:0] p_q, p_r;

  serial_divider #(.WIDTH(WIDTH)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .is_signed (is_signed),
    .a         (a),
    .b         (b),
    .result    (result),
    .remainder (remainder),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void ref_div(input logic [31:0] x, input logic [31:0] y, input bit s,
                                  output logic [31:0] q, output logic [31:0] r, output bit sp);
    int sx, sy;
    sp = 1'b0;
    if (y == 32'd0) begin
      q = 32'hFFFF_FFFF; r = x; sp = 1'b1;
    end else if (s && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000; r = 32'd0; sp = 1'b1;
    end else if (s) begin
      sx = x; sy = y;
      q = sx / sy; r = sx % sy;
    end else begin
      q = x / y; r = x % y;
    end
  endfunction

  always @(negedge clock) begin
    logic exp_busy, hit, match, cache_ok, sp;
    logic [31:0] q, r;
    if (reset) begin
      check("reset busy", busy, 32'd0);
      check("reset result", result, 32'd0);
      check("reset remainder", remainder, 32'd0);
      m_left = 0; m_hold = 0; m_cache = 0;
      m_a = 0; m_b = 0; m_s = 0; m_res = 0; m_rem = 0;
    end else begin
      match = (a == m_a) && (b == m_b) && (is_signed == m_s);
`ifdef DIV_CACHE_EN
      cache_ok = m_cache;
`else
      cache_ok = 1'b0;
`endif
      exp_busy = 1'b0;
      hit = 1'b0;
      if (m_left > 0) exp_busy = 1'b1;
      else if (start) begin
        if (match && (m_hold || cache_ok)) hit = 1'b1;
        else exp_busy = 1'b1;
      end
      check("busy", busy, exp_busy);
      check("result", result, m_res);
      check("remainder", remainder, m_rem);
      // Advance the model across the coming rising edge.
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_res = p_q; m_rem = p_r; m_hold = 1; m_cache = 1;
        end
      end else if (start) begin
        if (hit) m_hold = 1;
        else begin
          m_a = a; m_b = b; m_s = is_signed;
          ref_div(a, b, is_signed, q, r, sp);
          if (sp) begin
            m_res = q; m_rem = r; m_hold = 1; m_cache = 1;
          end else begin
            p_q = q; p_r = r; m_left = WIDTH; m_hold = 0;
          end
        end
      end else begin
        m_hold = 0;
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic run_req(input logic [31:0] ta, input logic [31:0] tb, input bit ts, output int n);
    a = ta; b = tb; is_signed = ts; start = 1'b1;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (!busy) break;
      n++;
      @(posedge clock);
      #1;
    end
    check("busy settles", busy, 32'd0);
    @(posedge clock);
    #1;
  endtask

  task automatic pick_tuple();
    case ($urandom_range(0, 5))
      0: a = 32'h8000_0000;
      1: a = $urandom_range(0, 20);
      2: a = 32'hFFFF_FFF9;
      default: a = $urandom >> $urandom_range(0, 31);
    endcase
    case ($urandom_range(0, 6))
      0: b = 32'd0;
      1: b = 32'hFFFF_FFFF;
      2: b = $urandom_range(1, 16);
      3: b = 32'd0 - $urandom_range(1, 16);
      default: b = $urandom >> $urandom_range(0, 31);
    endcase
    is_signed = 1'($urandom_range(0, 1));
  endtask

  initial begin
    int n;
    logic [31:0] q, r;
    bit sp;
    reset = 1'b1; start = 1'b0; is_signed = 1'b0; a = '0; b = '0;

    ref_div(32'd100, 32'd7, 1'b0, q, r, sp);
    check("model 100/7 q", q, 32'd14);
    check("model 100/7 r", r, 32'd2);
    ref_div(32'hFFFF_FFF9, 32'd2, 1'b1, q, r, sp);
    check("model -7/2 q", q, 32'hFFFF_FFFD);
    check("model -7/2 r", r, 32'hFFFF_FFFF);

    step(); step();
    reset = 1'b0;
    check("idle busy", busy, 32'd0);

    run_req(32'd100, 32'd7, 1'b0, n);
    check("100/7 busy cycles", n, 32'd33);
    check("100/7 q", result, 32'd14);
    check("100/7 r", remainder, 32'd2);
    step(); step(); step();
    check("held busy", busy, 32'd0);
    check("held q", result, 32'd14);

    run_req(32'd100, 32'd5, 1'b0, n);
    check("100/5 busy cycles", n, 32'd33);
    check("100/5 q", result, 32'd20);
    check("100/5 r", remainder, 32'd0);

    start = 1'b0; step();
    run_req(32'hFFFF_FFF9, 32'd2, 1'b1, n);
    check("-7/2 q", result, 32'hFFFF_FFFD);
    check("-7/2 r", remainder, 32'hFFFF_FFFF);
    run_req(32'hFFFF_FFF9, 32'd2, 1'b0, n);
    check("u 0xfffffff9/2 q", result, 32'h7FFF_FFFC);
    check("u 0xfffffff9/2 r", remainder, 32'd1);

    run_req(32'd5, 32'd0, 1'b0, n);
    check("5/0 u busy cycles", n, 32'd1);
    check("5/0 u q", result, 32'hFFFF_FFFF);
    check("5/0 u r", remainder, 32'd5);
    run_req(32'd5, 32'd0, 1'b1, n);
    check("5/0 s busy cycles", n, 32'd1);
    check("5/0 s q", result, 32'hFFFF_FFFF);
    run_req(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, n);
    check("ovf busy cycles", n, 32'd1);
    check("ovf q", result, 32'h8000_0000);
    check("ovf r", remainder, 32'd0);

    start = 1'b0; step();
    a = 32'd1000; b = 32'd3; is_signed = 1'b0; start = 1'b1;
    repeat (11) step();
    check("mid-run busy", busy, 32'd1);
    reset = 1'b1;
    #1;
    check("reset mid-run busy", busy, 32'd0);
    check("reset mid-run q", result, 32'd0);
    check("reset mid-run r", remainder, 32'd0);
    start = 1'b0;
    step();
    reset = 1'b0;
    step();
    run_req(32'd9, 32'd3, 1'b0, n);
    check("9/3 busy cycles", n, 32'd33);
    check("9/3 q", result, 32'd3);
    check("9/3 r", remainder, 32'd0);

    run_req(32'd100, 32'd7, 1'b0, n);
    start = 1'b0; step(); step();
    run_req(32'd100, 32'd7, 1'b0, n);
`ifdef DIV_CACHE_EN
    check("cached rem busy cycles", n, 32'd0);
`else
    check("recomputed rem busy cycles", n, 32'd33);
`endif
    check("rem 100/7", remainder, 32'd2);

    start = 1'b0;
    for (int cyc = 0; cyc < 6000; cyc++) begin
      int unsigned rv;
      rv = $urandom_range(0, 999);
      if (reset) reset = 1'b0;
      else if (rv < 3) reset = 1'b1;
      else if (!start) begin
        if (rv < 150) begin
          start = 1'b1;
          if (rv < 90) pick_tuple();
        end
      end else if (rv < 25) start = 1'b0;
      else if (rv < 45) pick_tuple();
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
